// File: rtl/coherence_bus_ctrl.sv
// Memory-side bus controller for two cores' icache/dcache pairs: arbitrates onto one RAM port,
// snoops the other core on coherence transactions and forwards modified lines cache-to-cache.
module coherence_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        ccack,
  input  logic [CPUS-1:0]        ccfwd,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;
  typedef enum logic [3:0] {IDLE, SNOOP, FWD0, FWD1, RD0, RD1, UPGR, WB, IFETCH} state_t;

  state_t state, next_state;
  logic   r, r_next;
  logic   d_last, d_last_next;
  logic   i_last, i_last_next;
  logic   two_word, two_word_next;
  logic   snoop_inv, snoop_inv_next;
  logic   s, access;

  logic [CPUS-1:0][WORD_W-1:0] iaddr_w, daddr_w, dstore_w, iload_w, dload_w, snoop_w;

  assign iaddr_w     = iaddr;
  assign daddr_w     = daddr;
  assign dstore_w    = dstore;
  assign iload       = iload_w;
  assign dload       = dload_w;
  assign ccsnoopaddr = snoop_w;

  assign s      = ~r;
  assign access = (ram_state_t'(ramstate) == RAM_ACCESS);

  // Round-robin between two requesters: on contention favour the core not served last.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      r         <= 1'b0;
      d_last    <= 1'b1;
      i_last    <= 1'b1;
      two_word  <= 1'b0;
      snoop_inv <= 1'b0;
    end else begin
      state     <= next_state;
      r         <= r_next;
      d_last    <= d_last_next;
      i_last    <= i_last_next;
      two_word  <= two_word_next;
      snoop_inv <= snoop_inv_next;
    end
  end

  always_comb begin
    next_state     = state;
    r_next         = r;
    d_last_next    = d_last;
    i_last_next    = i_last;
    two_word_next  = two_word;
    snoop_inv_next = snoop_inv;
    iwait          = '1;
    dwait          = '1;
    ccwait         = '0;
    ccinv          = '0;
    snoop_w        = '0;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;
    iload_w        = {CPUS{ramload}};
    dload_w        = {CPUS{ramload}};

    case (state)
      IDLE: begin
        if (|cctrans) begin
          r_next         = pick(cctrans, d_last);
          d_last_next    = r_next;
          snoop_inv_next = ccwrite[r_next];
          next_state     = SNOOP;
        end else if (|dWEN) begin
          r_next      = pick(dWEN, d_last);
          d_last_next = r_next;
          next_state  = WB;
        end else if (|dREN) begin
          r_next        = pick(dREN, d_last);
          d_last_next   = r_next;
          two_word_next = 1'b0;
          next_state    = RD0;
        end else if (|iREN) begin
          r_next      = pick(iREN, i_last);
          i_last_next = r_next;
          next_state  = IFETCH;
        end
      end

      SNOOP: begin
        ccwait[s]  = 1'b1;
        ccinv[s]   = snoop_inv;
        snoop_w[s] = daddr_w[r];
        if (ccfwd[s]) begin
          next_state = FWD0;
        end else if (ccack[s]) begin
          two_word_next = 1'b1;
          next_state    = dREN[r] ? RD0 : UPGR;
        end
      end

      // Snooper's dirty words go to the requester and to RAM in the same cycle.
      FWD0, FWD1: begin
        ccwait[s]  = 1'b1;
        ccinv[s]   = snoop_inv;
        snoop_w[s] = daddr_w[r];
        ramWEN     = 1'b1;
        ramaddr    = daddr_w[s];
        ramstore   = dstore_w[s];
        dload_w[r] = dstore_w[s];
        if (access) begin
          dwait      = '0;
          next_state = (state == FWD0) ? FWD1 : IDLE;
        end
      end

      RD0, RD1: begin
        ramREN  = 1'b1;
        ramaddr = daddr_w[r];
        if (access) begin
          dwait[r]   = 1'b0;
          next_state = (state == RD0 && two_word) ? RD1 : IDLE;
        end
      end

      UPGR: begin
        dwait[r]   = 1'b0;
        next_state = IDLE;
      end

      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_w[r];
        ramstore = dstore_w[r];
        if (access) begin
          dwait[r]   = 1'b0;
          next_state = IDLE;
        end
      end

      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_w[r];
        if (access) begin
          iwait[r]   = 1'b0;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: RAM model with random BUSY/ERROR latency, cache-side driver tasks,
// and a reference memory image giving the data each transaction must return or leave behind.
module tb_coherence_bus_ctrl;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST;
  logic [1:0] iREN, dREN, dWEN, cctrans, ccwrite, ccack, ccfwd;
  logic [1:0] iwait, dwait, ccwait, ccinv;
  logic [1:0][W-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic ramREN, ramWEN;
  logic [W-1:0] ramaddr, ramstore;
  logic [W-1:0] ramload = '0;
  logic [1:0] ramstate = 2'd0;

  int n_checks = 0;
  int n_fail = 0;

  coherence_bus_ctrl #(.CPUS(2), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccack(ccack), .ccfwd(ccfwd),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM contents (written only when the DUT's write completes) and the expected image.
  logic [W-1:0] ram_mem [logic [W-1:0]];
  logic [W-1:0] ref_mem [logic [W-1:0]];

  function automatic logic [W-1:0] init_word(input logic [W-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [W-1:0] ram_rd(input logic [W-1:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  int lat_cfg = 0;
  bit err_mode = 0;
  int busy_cnt = 0;

  always @(posedge CLK) begin
    #2;
    if (!(ramREN || ramWEN)) begin
      ramstate = 2'd0;
      busy_cnt = lat_cfg;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      ramstate = (err_mode && $urandom_range(0, 1) == 1) ? 2'd3 : 2'd1;
    end else begin
      ramstate = 2'd2;
      busy_cnt = lat_cfg;
    end
    ramload = ram_rd(ramaddr);
  end

  int dcnt [2] = '{0, 0};
  int icnt [2] = '{0, 0};
  int dpulse_cyc [2] = '{0, 0};
  int ipulse_cyc [2] = '{0, 0};
  logic [W-1:0] last_dload [2];
  logic [W-1:0] last_iload [2];
  int both_cnt = 0;
  int ren_cycles = 0;
  int cyc = 0;

  always @(negedge CLK) begin
    int low;
    if (!RST) begin
      cyc = cyc + 1;
      low = 0;
      for (int i = 0; i < 2; i++) begin
        if (!dwait[i]) begin
          dcnt[i]++;
          dpulse_cyc[i] = cyc;
          last_dload[i] = dload[i];
          low++;
        end
        if (!iwait[i]) begin
          icnt[i]++;
          ipulse_cyc[i] = cyc;
          last_iload[i] = iload[i];
          low++;
        end
      end
      if (dwait == 2'b00) both_cnt++;
      if (ramREN) ren_cycles++;
      if (ramWEN && ramstate == 2'd2) ram_mem[ramaddr] = ramstore;
      n_checks++;
      if ((low > 1 && !(low == 2 && dwait == 2'b00)) || (ramREN && ramWEN)) begin
        n_fail++;
        $display("FAIL bus_invariant: cycle %0d iwait=%b dwait=%b ramREN=%b ramWEN=%b", cyc, iwait, dwait,
                 ramREN, ramWEN);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ccack = '0; ccfwd = '0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic do_read(input int r, input logic [W-1:0] a);
    int bd = dcnt[r];
    int n = 0;
    dREN[r] = 1'b1;
    daddr[r] = a;
    while (dcnt[r] < bd + 1 && n < 60) begin tick(); n++; end
    dREN[r] = 1'b0;
    tick(); tick();
    n_checks++;
    if (dcnt[r] - bd != 1 || last_dload[r] !== ref_rd(a)) begin
      n_fail++;
      $display("FAIL read core%0d @%h: pulses=%0d data=%h, required pulses=1 data=%h", r, a, dcnt[r] - bd,
               last_dload[r], ref_rd(a));
    end
  endtask

  task automatic do_wb(input int r, input logic [W-1:0] a, input logic [W-1:0] d);
    int bd = dcnt[r];
    int n = 0;
    dWEN[r] = 1'b1;
    daddr[r] = a;
    dstore[r] = d;
    while (dcnt[r] < bd + 1 && n < 60) begin tick(); n++; end
    dWEN[r] = 1'b0;
    ref_mem[a] = d;
    tick(); tick();
    n_checks++;
    if (dcnt[r] - bd != 1 || ram_rd(a) !== d) begin
      n_fail++;
      $display("FAIL writeback core%0d @%h: pulses=%0d ram=%h, required pulses=1 ram=%h", r, a, dcnt[r] - bd,
               ram_rd(a), d);
    end
  endtask

  task automatic do_ifetch(input int r, input logic [W-1:0] a);
    int bi = icnt[r];
    int n = 0;
    iREN[r] = 1'b1;
    iaddr[r] = a;
    while (icnt[r] < bi + 1 && n < 60) begin tick(); n++; end
    iREN[r] = 1'b0;
    tick(); tick();
    n_checks++;
    if (icnt[r] - bi != 1 || last_iload[r] !== ref_rd(a)) begin
      n_fail++;
      $display("FAIL ifetch core%0d @%h: pulses=%0d data=%h, required pulses=1 data=%h", r, a, icnt[r] - bi,
               last_iload[r], ref_rd(a));
    end
  endtask

  // mode 0: allocation, snooper acks; mode 1: allocation, snooper forwards d0/d1; mode 2: upgrade.
  task automatic do_coh(input int r, input logic [W-1:0] a, input logic wr, input int mode,
                        input logic [W-1:0] d0, input logic [W-1:0] d1);
    int s = 1 - r;
    int bd_r = dcnt[r];
    int bd_s = dcnt[s];
    int bb = both_cnt;
    int n = 0;
    int exp_r = (mode == 2) ? 1 : 2;
    logic [W-1:0] e0, e1;
    cctrans[r] = 1'b1;
    ccwrite[r] = wr;
    daddr[r] = a;
    dREN[r] = (mode != 2);
    while (ccwait[s] !== 1'b1 && n < 40) begin tick(); n++; end
    n_checks++;
    if (ccwait[s] !== 1'b1 || ccwait[r] !== 1'b0 || ccsnoopaddr[s] !== a || ccinv[s] !== wr) begin
      n_fail++;
      $display("FAIL snoop_req core%0d: ccwait=%b snoopaddr=%h ccinv=%b, required ccwait[%0d]=1 snoopaddr=%h ccinv=%b",
               r, ccwait, ccsnoopaddr[s], ccinv[s], s, a, wr);
    end
    if (mode == 1) begin
      ccfwd[s] = 1'b1; dWEN[s] = 1'b1; daddr[s] = a; dstore[s] = d0;
      e0 = d0; e1 = d1;
    end else begin
      ccack[s] = 1'b1;
      e0 = ref_rd(a); e1 = ref_rd(a + 32'd4);
    end
    n = 0;
    while (dcnt[r] < bd_r + 1 && n < 60) begin tick(); n++; end
    ccack[s] = 1'b0;
    ccfwd[s] = 1'b0;
    n_checks++;
    if (dcnt[r] != bd_r + 1 || (mode != 2 && last_dload[r] !== e0)) begin
      n_fail++;
      $display("FAIL coh_word0 core%0d mode%0d: pulses=%0d data=%h, required pulses=1 data=%h", r, mode,
               dcnt[r] - bd_r, last_dload[r], e0);
    end
    if (mode != 2) begin
      daddr[r] = a + 32'd4;
      if (mode == 1) begin daddr[s] = a + 32'd4; dstore[s] = d1; end
      n_checks++;
      if (ccwait[s] !== (mode == 1)) begin
        n_fail++;
        $display("FAIL coh_hold core%0d mode%0d: ccwait[%0d]=%b between words, required %b", r, mode, s,
                 ccwait[s], (mode == 1));
      end
      n = 0;
      while (dcnt[r] < bd_r + 2 && n < 60) begin tick(); n++; end
      n_checks++;
      if (dcnt[r] != bd_r + 2 || last_dload[r] !== e1) begin
        n_fail++;
        $display("FAIL coh_word1 core%0d mode%0d: pulses=%0d data=%h, required pulses=2 data=%h", r, mode,
                 dcnt[r] - bd_r, last_dload[r], e1);
      end
    end
    cctrans[r] = 1'b0; dREN[r] = 1'b0; ccwrite[r] = 1'b0;
    if (mode == 1) begin
      dWEN[s] = 1'b0;
      ref_mem[a] = d0;
      ref_mem[a + 32'd4] = d1;
    end
    tick(); tick();
    n_checks++;
    if (dcnt[r] - bd_r != exp_r || ccwait[s] !== 1'b0 ||
        dcnt[s] - bd_s != ((mode == 1) ? 2 : 0) || both_cnt - bb != ((mode == 1) ? 2 : 0)) begin
      n_fail++;
      $display("FAIL coh_done core%0d mode%0d: req_pulses=%0d snp_pulses=%0d joint=%0d ccwait=%b, required %0d/%0d/%0d ccwait[%0d]=0",
               r, mode, dcnt[r] - bd_r, dcnt[s] - bd_s, both_cnt - bb, ccwait, exp_r,
               (mode == 1) ? 2 : 0, (mode == 1) ? 2 : 0, s);
    end
    if (mode == 1) begin
      n_checks++;
      if (ram_rd(a) !== d0 || ram_rd(a + 32'd4) !== d1) begin
        n_fail++;
        $display("FAIL coh_writethrough @%h: ram=%h,%h required %h,%h", a, ram_rd(a), ram_rd(a + 32'd4), d0, d1);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    tick(); tick();
    n_checks++;
    if (iwait !== 2'b11 || dwait !== 2'b11 || ccwait !== 2'b00 || ccinv !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_waits: iwait=%b dwait=%b ccwait=%b ccinv=%b, required 11 11 00 00", iwait, dwait, ccwait,
               ccinv);
    end
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== '0 || ramstore !== '0 || ccsnoopaddr !== '0) begin
      n_fail++;
      $display("FAIL reset_ram: ramREN=%b ramWEN=%b ramaddr=%h ramstore=%h snoopaddr=%h, required all zero", ramREN,
               ramWEN, ramaddr, ramstore, ccsnoopaddr);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_ifetch();
    int br = ren_cycles;
    lat_cfg = 2;
    err_mode = 0;
    ram_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    do_ifetch(0, 32'h40);
    n_checks++;
    if (ren_cycles - br != 3) begin
      n_fail++;
      $display("FAIL ifetch_ren_cycles: %0d, required 3", ren_cycles - br);
    end
    lat_cfg = 0;
  endtask

  task automatic test_coh_ack();
    do_coh(0, 32'h100, 1'b0, 0, '0, '0);
  endtask

  task automatic test_coh_fwd();
    lat_cfg = 1;
    do_coh(1, 32'h200, 1'b1, 1, 32'hA, 32'hB);
    lat_cfg = 0;
  endtask

  task automatic test_upgrade();
    do_coh(0, 32'h180, 1'b1, 2, '0, '0);
    do_coh(1, 32'h188, 1'b1, 2, '0, '0);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    cctrans = 2'b11;
    dREN = 2'b11;
    daddr[0] = 32'h300;
    daddr[1] = 32'h380;
    do_coh(0, 32'h300, 1'b0, 0, '0, '0);
    do_coh(1, 32'h380, 1'b0, 0, '0, '0);
  endtask

  task automatic test_wb_ifetch();
    logic [W-1:0] a = 32'h2000 + 32'($urandom_range(0, 7) << 2);
    logic [W-1:0] b = 32'h3000 + 32'($urandom_range(0, 7) << 2);
    logic [W-1:0] d = $urandom;
    int bd = dcnt[0];
    int bi = icnt[1];
    int n = 0;
    dWEN[0] = 1'b1; daddr[0] = a; dstore[0] = d;
    iREN[1] = 1'b1; iaddr[1] = b;
    while (dcnt[0] < bd + 1 && n < 60) begin tick(); n++; end
    dWEN[0] = 1'b0;
    ref_mem[a] = d;
    n = 0;
    while (icnt[1] < bi + 1 && n < 60) begin tick(); n++; end
    iREN[1] = 1'b0;
    tick(); tick();
    n_checks++;
    if (dcnt[0] != bd + 1 || icnt[1] != bi + 1 || !(dpulse_cyc[0] < ipulse_cyc[1])) begin
      n_fail++;
      $display("FAIL wb_before_ifetch: wb_pulses=%0d@%0d if_pulses=%0d@%0d, required one each with wb first",
               dcnt[0] - bd, dpulse_cyc[0], icnt[1] - bi, ipulse_cyc[1]);
    end
    n_checks++;
    if (ram_rd(a) !== d || last_iload[1] !== ref_rd(b)) begin
      n_fail++;
      $display("FAIL wb_ifetch_data: ram=%h iload=%h, required ram=%h iload=%h", ram_rd(a), last_iload[1], d,
               ref_rd(b));
    end
  endtask

  task automatic test_single_read();
    do_read(1, 32'h440);
    do_wb(0, 32'h444, 32'h1234_5678);
    do_read(0, 32'h444);
  endtask

  task automatic test_random();
    err_mode = 1;
    for (int k = 0; k < 40; k++) begin
      int kind = $urandom_range(0, 5);
      int r = $urandom_range(0, 1);
      logic [W-1:0] a = 32'h1000 + 32'($urandom_range(0, 15) << 3);
      lat_cfg = $urandom_range(0, 3);
      case (kind)
        0: do_read(r, a);
        1: do_wb(r, a, $urandom);
        2: do_ifetch(r, a);
        3: do_coh(r, a, 1'($urandom_range(0, 1)), 0, '0, '0);
        4: do_coh(r, a, 1'($urandom_range(0, 1)), 1, $urandom, $urandom);
        default: do_coh(r, a, 1'b1, 2, '0, '0);
      endcase
    end
    err_mode = 0;
    lat_cfg = 0;
  endtask

  task automatic test_reset_fwd1();
    logic [W-1:0] d0 = $urandom;
    int bd = dcnt[0];
    int n = 0;
    lat_cfg = 3;
    cctrans[0] = 1'b1; dREN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h500;
    while (ccwait[1] !== 1'b1 && n < 40) begin tick(); n++; end
    ccfwd[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h500; dstore[1] = d0;
    n = 0;
    while (dcnt[0] < bd + 1 && n < 60) begin tick(); n++; end
    ccfwd[1] = 1'b0;
    daddr[0] = 32'h504; daddr[1] = 32'h504; dstore[1] = $urandom;
    ref_mem[32'h500] = d0;
    #2;
    n_checks++;
    if (ccwait[1] !== 1'b1 || ramWEN !== 1'b1 || dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL fwd1_pending: ccwait=%b ramWEN=%b dwait=%b, required ccwait[1]=1 ramWEN=1 dwait=11", ccwait,
               ramWEN, dwait);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (iwait !== 2'b11 || dwait !== 2'b11 || ccwait !== 2'b00 || ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_fwd1: iwait=%b dwait=%b ccwait=%b ramWEN=%b, required 11 11 00 0", iwait, dwait,
               ccwait, ramWEN);
    end
    tick();
    n_checks++;
    if (iwait !== 2'b11 || dwait !== 2'b11 || ccwait !== 2'b00 || ramWEN !== 1'b0 || ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_edge: iwait=%b dwait=%b ccwait=%b ramWEN=%b ramREN=%b, required 11 11 00 0 0", iwait,
               dwait, ccwait, ramWEN, ramREN);
    end
    clear_inputs();
    RST = 1'b0;
    tick(); tick();
    lat_cfg = 0;
    do_read(1, 32'h500);
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_ifetch();
    test_coh_ack();
    test_coh_fwd();
    test_simultaneous();
    test_wb_ifetch();
    test_single_read();
    test_upgrade();
    test_random();
    test_reset_fwd1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Memory-side responder for the two per-core cache pairs (icache + dcache per core).
- Arbitrates cache requests onto the single RAM port.
- Services dcache block allocations (two words) with snooping of the other core.
- Forwards modified data cache-to-cache, writing it through to RAM at the same time.
- Handles write-backs, flushes, upgrade invalidations and icache fetches.
- It is the far end of the dcache IDLE/ALLOC0/ALLOC1/WB0/WB1/FLUSH*/FWD0/FWD1/INV protocol.

Parameters:
- CPUS, 2, number of cores; only 2 is supported.
- WORD_W, 32, width of address and data words.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- iREN  in  2  per-core icache read request.
- iaddr  in  2xWORD_W  per-core icache word address.
- iwait  out  2  per-core icache stall; low for exactly one cycle when iload is valid.
- iload  out  2xWORD_W  per-core icache data.
- dREN  in  2  per-core dcache read request.
- dWEN  in  2  per-core dcache write request.
- daddr  in  2xWORD_W  per-core dcache word address.
- dstore  in  2xWORD_W  per-core dcache write/forward data.
- dwait  out  2  per-core dcache stall; low one cycle per completed word.
- dload  out  2xWORD_W  per-core dcache read data.
- cctrans  in  2  coherence transaction request (allocation or upgrade).
- ccwrite  in  2  requester intends to write, so the other copy must be invalidated.
- ccack  in  2  snoop reply: line not modified, no data.
- ccfwd  in  2  snoop reply: line modified; snooper supplies two words via dWEN/daddr/dstore.
- ccwait  out  2  snoop request to a core.
- ccinv  out  2  invalidate qualifier, valid with ccwait.
- ccsnoopaddr  out  2xWORD_W  snoop address.
- ramREN  out  1  RAM read.
- ramWEN  out  1  RAM write.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM state: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:

Reset:
- Outputs: iwait=2'b11, dwait=2'b11, ccwait=0, ccinv=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ccsnoopaddr=0.
- State: state=IDLE, d_last=1, i_last=1.
- Reset asserted mid-transaction aborts the transaction to IDLE immediately; there is no partial RAM write guarantee.

States: IDLE, SNOOP, FWD0, FWD1, RD0, RD1, UPGR, WB, IFETCH.

IDLE priority:
1. Any cctrans → coherence grant.
2. Any dWEN without cctrans → WB.
3. Any dREN without cctrans → RD0, single word, returns to IDLE after word 0.
4. Any iREN → IFETCH.

Arbitration:
- Within a class, round-robin: grant the core != *_last when both request, then update *_last.
- Latch r = granted core, s = ~r.

Coherence grant:
- Go to SNOOP.
- Drive ccwait[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[s]=ccwrite[r]. These hold until the snooper replies.

SNOOP:
- ccfwd[s] → FWD0.
- ccack[s] with dREN[r] → RD0.
- ccack[s] without dREN[r] → UPGR.
- Both ccfwd and ccack → ccfwd wins.
- No reply → stay; there is no timeout.

FWD0/FWD1:
- RAM side: ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
- Core side: dload[r]=dstore[s].
- On ramstate==ACCESS: dwait[r]=0 and dwait[s]=0 for that cycle, then advance FWD0→FWD1→IDLE.
- ccwait[s] is held through FWD1 and drops on entering IDLE.

RD0/RD1:
- ramREN=1, ramaddr=daddr[r], dload[r]=ramload.
- On ACCESS: dwait[r]=0, then advance RD0→RD1→IDLE.
- Coherent allocations use RD0 and RD1.

UPGR:
- One cycle with dwait[r]=0, then IDLE.

WB:
- ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r].
- On ACCESS: dwait[r]=0, then IDLE.
- Each WB0/WB1/FLUSH word is a separate WB transaction.

IFETCH:
- ramREN=1, ramaddr=iaddr[r], iload[r]=ramload.
- On ACCESS: iwait[r]=0, then IDLE.

RAM status handling:
- BUSY or ERROR: hold all outputs and keep waits high; ERROR is retried.

Invariants and ordering:
- Only one RAM access in flight.
- At most one wait bit low per cycle, except in FWD where both are low.
- Requests are sampled only in IDLE. A request arriving while busy is served no earlier than the cycle after return to IDLE.
- dcache requests starve icache while they persist.

Test Plan:
- Core0 iREN, iaddr=0x40, RAM returns 0xDEADBEEF after 2 BUSY cycles → iwait[0] low exactly one cycle, iload[0]=0xDEADBEEF, ramREN high for 3 cycles.
- Core0 cctrans+dREN daddr=0x100, core1 ccack → ccwait[1]=1, ccsnoopaddr[1]=0x100, ccinv[1]=0; RAM reads 0x100 then 0x104; dwait[0] pulses twice.
- Core1 cctrans+dREN+ccwrite daddr=0x200, core0 ccfwd with dstore 0xA/0xB at 0x200/0x204 → ccinv[0]=1; ramWEN writes 0xA,0xB; dload[1]=0xA then 0xB; dwait[0] and dwait[1] low together twice.
- Both cores cctrans in the same cycle from reset → core0 is served first (d_last=1), core1 is served next after IDLE; no deadlock.
- Core0 dWEN (WB) and core1 iREN simultaneously → WB completes first, then IFETCH.
- RST asserted during FWD1 → next edge: all waits high, ccwait=0, ramWEN=0, state IDLE.
